// File: rtl/mem_io_bridge.sv
// mem_io_bridge
// Connects the SLC-3 MAR/MDR memory port to the external 1Mx16 asynchronous SRAM.
// It also decodes one CPU address as a memory-mapped I/O register:
//   - reads of that address return the synchronized board switches;
//   - writes to that address load the 4-digit hex display register.
// Each access follows a short strobe sequence. The CPU sees a one-cycle Ack when the access is finished.
module mem_io_bridge #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [15:0] A,
    input  logic [15:0] Data_CPU_In,
    output logic [15:0] Data_CPU_Out,
    output logic        Ack,
    input  logic [15:0] Switches,
    output logic [3:0]  HEX0,
    output logic [3:0]  HEX1,
    output logic [3:0]  HEX2,
    output logic [3:0]  HEX3,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    output logic [15:0] Data_Mem_Out,
    input  logic [15:0] Data_Mem_In
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic        armed;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic [3:0]  wait_cnt;
    logic [15:0] sw_meta;
    logic [15:0] sw_sync;
    logic [15:0] hex_q;
    logic        accept;
    logic        is_io;
    logic        last_access;

    // A request is only taken from IDLE.
    // It also needs Req to have been seen low since the previous access.
    assign accept      = (state == IDLE) && Req && armed;
    assign is_io       = (A == IO_ADDR);
    assign last_access = (state == ACCESS) && (wait_cnt == 4'd0);

    assign ADDR         = {4'b0000, addr_q};
    assign Data_Mem_Out = (state == ACCESS && wr_q) ? data_q : 16'h0000;

    assign HEX0 = hex_q[3:0];
    assign HEX1 = hex_q[7:4];
    assign HEX2 = hex_q[11:8];
    assign HEX3 = hex_q[15:12];

    // State register.
    // An asynchronous reset returns the FSM to IDLE, which releases every strobe at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and Moore-style strobe decode.
    // OE is driven only for reads and WE only in ACCESS for writes, so OE and WE are never low together.
    always_comb begin
        next_state = state;
        CE         = 1'b1;
        UB         = 1'b1;
        LB         = 1'b1;
        OE         = 1'b1;
        WE         = 1'b1;
        Ack        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = is_io ? DONE : SETUP;
                end
            end
            SETUP: begin
                CE         = 1'b0;
                UB         = 1'b0;
                LB         = 1'b0;
                OE         = wr_q;
                next_state = ACCESS;
            end
            ACCESS: begin
                CE = 1'b0;
                UB = 1'b0;
                LB = 1'b0;
                OE = wr_q;
                WE = !wr_q;
                if (wait_cnt == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                Ack        = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Re-arm whenever Req is seen low, and disarm on accept.
    // As a result, a request held high yields only a single access.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            armed <= 1'b1;
        end else if (!Req) begin
            armed <= 1'b1;
        end else if (accept) begin
            armed <= 1'b0;
        end
    end

    // Capture the request at accept.
    // Later changes on A, Wr and Data_CPU_In cannot disturb an access that is already in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q <= 16'h0000;
            wr_q   <= 1'b0;
            data_q <= 16'h0000;
        end else if (accept) begin
            addr_q <= A;
            wr_q   <= Wr;
            data_q <= Data_CPU_In;
        end
    end

    // SETUP loads the ACCESS wait counter; ACCESS then counts it down to zero.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= 4'd0;
        end else if (state == SETUP) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == ACCESS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sw_meta <= 16'h0000;
            sw_sync <= 16'h0000;
        end else begin
            sw_meta <= Switches;
            sw_sync <= sw_meta;
        end
    end

    // Hex display register.
    // It loads directly from the CPU write data on an I/O write accept.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hex_q <= 16'h0000;
        end else if (accept && is_io && Wr) begin
            hex_q <= Data_CPU_In;
        end
    end

    // Read data register. It loads in two cases:
    //   - on an I/O read accept, with the synchronized switches;
    //   - on the edge that ends the last ACCESS cycle of an SRAM read, with the SRAM data.
    // Writes leave it untouched.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Data_CPU_Out <= 16'h0000;
        end else if (accept && is_io && !Wr) begin
            Data_CPU_Out <= sw_sync;
        end else if (last_access && !wr_q) begin
            Data_CPU_Out <= Data_Mem_In;
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge.
// It uses two instances:
//   - the default-latency instance runs the table and the corner sequences;
//   - a WAIT_CYCLES=4 instance covers the stretched ACCESS phase.
module tb_mem_io_bridge;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic [15:0] exp_out;
        logic [15:0] exp_hex;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] exp_out;
        logic [15:0] exp_hex;
        int          lat;
    } sb_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req;
    logic        Req4;
    logic        Wr;
    logic [15:0] A;
    logic [15:0] Data_CPU_In;
    logic [15:0] Switches;

    logic [15:0] Data_CPU_Out;
    logic        Ack;
    logic [3:0]  HEX0, HEX1, HEX2, HEX3;
    logic        CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    logic [15:0] Data_Mem_Out;
    logic [15:0] Data_Mem_In;

    logic [15:0] Data_CPU_Out4;
    logic        Ack4;
    logic [3:0]  HEX0_4, HEX1_4, HEX2_4, HEX3_4;
    logic        CE4, UB4, LB4, OE4, WE4;
    logic [19:0] ADDR4;
    logic [15:0] Data_Mem_Out4;
    logic [15:0] Data_Mem_In4;

    logic [15:0] sram [0:65535];

    int          tests = 0;
    int          fails = 0;
    sb_t         sb_q[$];
    vec_t        vecs [14];

    logic [2:0]  tr_sel [0:39];
    logic        tr_oe  [0:39];
    logic        tr_we  [0:39];
    logic [15:0] tr_dmo [0:39];
    logic [19:0] tr_addr[0:39];
    logic        ce_low;
    int          ack_cyc;

    mem_io_bridge dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .A(A),
        .Data_CPU_In(Data_CPU_In), .Data_CPU_Out(Data_CPU_Out), .Ack(Ack),
        .Switches(Switches), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR),
        .Data_Mem_Out(Data_Mem_Out), .Data_Mem_In(Data_Mem_In)
    );

    mem_io_bridge #(.WAIT_CYCLES(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Req(Req4), .Wr(Wr), .A(A),
        .Data_CPU_In(Data_CPU_In), .Data_CPU_Out(Data_CPU_Out4), .Ack(Ack4),
        .Switches(Switches), .HEX0(HEX0_4), .HEX1(HEX1_4), .HEX2(HEX2_4), .HEX3(HEX3_4),
        .CE(CE4), .UB(UB4), .LB(LB4), .OE(OE4), .WE(WE4), .ADDR(ADDR4),
        .Data_Mem_Out(Data_Mem_Out4), .Data_Mem_In(Data_Mem_In4)
    );

    // 10-time-unit clock; the rising edge is the active edge.
    always #5 Clk = ~Clk;

    // Behavioural SRAM for the main instance.
    // It writes on any clock edge where CE and WE are low, and reads combinationally while CE and OE are low.
    always @(posedge Clk) begin
        if (!CE && !WE) sram[ADDR[15:0]] <= Data_Mem_Out;
    end
    assign Data_Mem_In = (!CE && !OE) ? sram[ADDR[15:0]] : 16'h0000;

    // The slow instance sees an address-derived pattern, so its read data is predictable without a memory.
    assign Data_Mem_In4 = (!CE4 && !OE4) ? (ADDR4[15:0] ^ 16'h5A5A) : 16'h0000;

    // Single-point comparison helper; every check in the bench is counted here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one CPU access on the main instance and pushes its expected result to the scoreboard.
    // Timing:
    //   - Switches change sw_lead edges before Req rises;
    //   - cycle 0 is the accept cycle;
    //   - strobes are traced per cycle;
    //   - the scoreboard entry is popped and checked when Ack shows up.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] sw, input int sw_lead, input logic hold,
                                 input logic [15:0] exp_out, input logic [15:0] exp_hex, input int lat);
        sb_t e;
        sb_t got;
        logic seen;
        e.exp_out = exp_out;
        e.exp_hex = exp_hex;
        e.lat     = lat;
        @(posedge Clk);
        #1;
        Switches = sw;
        repeat (sw_lead) @(posedge Clk);
        #1;
        Wr          = wr;
        A           = addr;
        Data_CPU_In = wdata;
        Req         = 1'b1;
        sb_q.push_back(e);
        seen    = 1'b0;
        ce_low  = 1'b0;
        ack_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (c == 1 && !hold) Req = 1'b0;
            tr_sel[c]  = {CE, UB, LB};
            tr_oe[c]   = OE;
            tr_we[c]   = WE;
            tr_dmo[c]  = Data_Mem_Out;
            tr_addr[c] = ADDR;
            if (!CE) ce_low = 1'b1;
            if (Ack) begin
                got = sb_q.pop_front();
                checkOutput("sb_data", Data_CPU_Out, got.exp_out);
                checkOutput("sb_hex", {HEX3, HEX2, HEX1, HEX0}, got.exp_hex);
                checkOutput("sb_latency", c, got.lat);
                ack_cyc = c;
                seen    = 1'b1;
                break;
            end
        end
        if (!seen) begin
            Req = 1'b0;
            void'(sb_q.pop_front());
        end
        checkOutput("ack_within_bound", seen, 1'b1);
    endtask

    // Hard stop in case something stalls the whole simulation.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, traced SRAM accesses, reset mid-access, table, held request, switch sync, slow instance.
    initial begin
        int acks;
        logic ce_seen;
        logic [6:0] ce4_p, oe4_p, we4_p;
        int ack4;

        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 3};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 3};
        vecs[2]  = '{1'b1, 16'h0010, 16'h1111, 16'h0000, 16'hBEEF, 16'h0000, 3};
        vecs[3]  = '{1'b1, 16'hFFFF, 16'hCAFE, 16'h0000, 16'hBEEF, 16'hCAFE, 1};
        vecs[4]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h00A5, 16'hCAFE, 1};
        vecs[5]  = '{1'b1, 16'h0020, 16'h5A5A, 16'h00A5, 16'h00A5, 16'hCAFE, 3};
        vecs[6]  = '{1'b0, 16'h0010, 16'h0000, 16'h00A5, 16'h1111, 16'hCAFE, 3};
        vecs[7]  = '{1'b0, 16'h0020, 16'h0000, 16'h00A5, 16'h5A5A, 16'hCAFE, 3};
        vecs[8]  = '{1'b1, 16'hFFFE, 16'h7777, 16'h00A5, 16'h5A5A, 16'hCAFE, 3};
        vecs[9]  = '{1'b0, 16'hFFFE, 16'h0000, 16'h00A5, 16'h7777, 16'hCAFE, 3};
        vecs[10] = '{1'b1, 16'hFFFF, 16'h1357, 16'h00A5, 16'h7777, 16'h1357, 1};
        vecs[11] = '{1'b0, 16'hFFFF, 16'h0000, 16'h3C3C, 16'h3C3C, 16'h1357, 1};
        vecs[12] = '{1'b1, 16'h0000, 16'h0042, 16'h3C3C, 16'h3C3C, 16'h1357, 3};
        vecs[13] = '{1'b0, 16'h0000, 16'h0000, 16'h3C3C, 16'h0042, 16'h1357, 3};

        Reset       = 1'b0;
        Req         = 1'b0;
        Req4        = 1'b0;
        Wr          = 1'b0;
        A           = 16'h0000;
        Data_CPU_In = 16'h0000;
        Switches    = 16'h0000;

        // Reset state, observed before any clock edge.
        #2;
        checkOutput("rst_strobes", {CE, UB, LB, OE, WE}, 5'b11111);
        checkOutput("rst_ack", Ack, 1'b0);
        checkOutput("rst_data", Data_CPU_Out, 16'h0000);
        checkOutput("rst_hex", {HEX3, HEX2, HEX1, HEX0}, 16'h0000);
        checkOutput("rst_addr", ADDR, 20'h00000);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;

        // Traced SRAM write: CE/UB/LB low in cycles 1-2, WE low only in cycle 2.
        applyStimulus(1'b1, 16'h0010, 16'h1234, 16'h0000, 1, 1'b0, 16'h0000, 16'h0000, 3);
        checkOutput("wr_sel_c1", tr_sel[1], 3'b000);
        checkOutput("wr_sel_c2", tr_sel[2], 3'b000);
        checkOutput("wr_sel_c3", tr_sel[3], 3'b111);
        checkOutput("wr_we_trace", {tr_we[0], tr_we[1], tr_we[2], tr_we[3]}, 4'b1101);
        checkOutput("wr_oe_trace", {tr_oe[0], tr_oe[1], tr_oe[2], tr_oe[3]}, 4'b1111);
        checkOutput("wr_dmo_c2", tr_dmo[2], 16'h1234);
        checkOutput("wr_addr_c1", tr_addr[1], 20'h00010);
        checkOutput("wr_addr_c2", tr_addr[2], 20'h00010);

        // Traced SRAM read of the same word: OE low in cycles 1-2, WE never low.
        applyStimulus(1'b0, 16'h0010, 16'h0000, 16'h0000, 1, 1'b0, 16'h1234, 16'h0000, 3);
        checkOutput("rd_oe_trace", {tr_oe[0], tr_oe[1], tr_oe[2], tr_oe[3]}, 4'b1001);
        checkOutput("rd_we_trace", {tr_we[0], tr_we[1], tr_we[2], tr_we[3]}, 4'b1111);

        // Repeat write, with reset asserted during ACCESS.
        // Strobes must release without a clock edge, and no Ack may follow.
        @(posedge Clk);
        #1;
        Wr          = 1'b1;
        A           = 16'h0010;
        Data_CPU_In = 16'h1234;
        Req         = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Req = 1'b0;
        @(negedge Clk);
        checkOutput("rst_mid_we_before", WE, 1'b0);
        #1;
        Reset = 1'b0;
        #1;
        checkOutput("rst_mid_strobes", {CE, UB, LB, OE, WE}, 5'b11111);
        checkOutput("rst_mid_ack", Ack, 1'b0);
        checkOutput("rst_mid_data", Data_CPU_Out, 16'h0000);
        acks = 0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            if (Ack) acks++;
        end
        checkOutput("rst_mid_no_ack", acks, 0);

        // Table-driven accesses through the scoreboard.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].sw, 3, 1'b0,
                          vecs[i].exp_out, vecs[i].exp_hex, vecs[i].lat);
            checkOutput($sformatf("vec%0d_ce_used", i), ce_low, (vecs[i].addr != 16'hFFFF));
        end

        // Held request.
        // Req is held high for 10 cycles after Ack; no second access may start.
        applyStimulus(1'b0, 16'h0020, 16'h0000, 16'h3C3C, 3, 1'b1, 16'h5A5A, 16'h1357, 3);
        acks    = 0;
        ce_seen = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            if (Ack) acks++;
            if (!CE) ce_seen = 1'b1;
        end
        checkOutput("held_acks", acks, 0);
        checkOutput("held_ce_idle", ce_seen, 1'b0);
        @(posedge Clk);
        #1;
        Req = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h3C3C, 0, 1'b0, 16'h0042, 16'h1357, 3);

        // Switch synchronizer depth.
        // A change one cycle before accept is not yet visible; a change two cycles before is visible.
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 3, 1'b0, 16'h0000, 16'h1357, 1);
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 1'b0, 16'h0000, 16'h1357, 1);
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 3, 1'b0, 16'h0000, 16'h1357, 1);
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 2, 1'b0, 16'hFFFF, 16'h1357, 1);
        checkOutput("sb_drained", sb_q.size(), 0);

        // WAIT_CYCLES=4 instance: a read whose A and Wr are toggled during ACCESS.
        // The check covers latency, strobe shape and held address.
        @(posedge Clk);
        #1;
        A           = 16'h0040;
        Wr          = 1'b0;
        Data_CPU_In = 16'h0000;
        Req4        = 1'b1;
        ce4_p       = 7'b1111111;
        oe4_p       = 7'b1111111;
        we4_p       = 7'b1111111;
        ack4        = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (c == 1) Req4 = 1'b0;
            if (c < 7) begin
                ce4_p[6-c] = CE4 | UB4 | LB4;
                oe4_p[6-c] = OE4;
                we4_p[6-c] = WE4;
            end
            if (c == 2) checkOutput("w4_addr_c2", ADDR4, 20'h00040);
            if (c == 3) begin
                A           = 16'h1234;
                Wr          = 1'b1;
                Data_CPU_In = 16'hFFFF;
            end
            if (c == 5) checkOutput("w4_addr_c5", ADDR4, 20'h00040);
            if (Ack4) begin
                ack4 = c;
                checkOutput("w4_data", Data_CPU_Out4, 16'h0040 ^ 16'h5A5A);
                break;
            end
        end
        checkOutput("w4_latency", ack4, 6);
        checkOutput("w4_ce_trace", ce4_p, 7'b1000001);
        checkOutput("w4_oe_trace", oe4_p, 7'b1000001);
        checkOutput("w4_we_trace", we4_p, 7'b1111111);
        checkOutput("w4_hex_untouched", {HEX3_4, HEX2_4, HEX1_4, HEX0_4}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sequenced bridge between the SLC-3 datapath memory port (MAR/MDR side) and the external 1Mx16 asynchronous SRAM.
- Adds memory-mapped I/O: reads of IO_ADDR return the synchronized switches; writes to IO_ADDR latch the 4-digit hex display register.
- Sits directly downstream of the CPU top level: takes the CPU's address, write data and access request, drives the SRAM strobes, and returns read data plus a completion acknowledge.

Parameters:
- WAIT_CYCLES, 1, number of ACCESS-state cycles per SRAM access; legal range 1..15.
- IO_ADDR, 16'hFFFF, CPU address decoded as the switch/hex I/O register.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  1  access request from the CPU, level-sensitive.
- Wr  input  1  1 = write, 0 = read; sampled at accept.
- A  input  16  CPU word address; sampled at accept.
- Data_CPU_In  input  16  write data from MDR; sampled at accept.
- Data_CPU_Out  output  16  registered read data to MDR.
- Ack  output  1  one-cycle completion pulse.
- Switches  input  16  asynchronous board switches.
- HEX0, HEX1, HEX2, HEX3  output  4 each  hex register nibbles [3:0], [7:4], [11:8], [15:12].
- CE, UB, LB, OE, WE  output  1 each  SRAM strobes, active-low.
- ADDR  output  20  SRAM address, {4'b0000, latched A}.
- Data_Mem_Out  output  16  write data toward the external tristate buffer; driven only while WE=0.
- Data_Mem_In  input  16  read data from the external tristate buffer.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE; armed = 1; Ack = 0.
  - CE = UB = LB = OE = WE = 1.
  - Data_CPU_Out = 0; hex register = 0; ADDR = 0; switch synchronizer = 0.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - Accept when Req=1 and armed=1; latch A, Wr and Data_CPU_In; clear armed.
  - Req=0 in any cycle sets armed=1. Each access needs Req low for at least one cycle after its Ack; a held-high Req never starts a second access.
- Accept with A == IO_ADDR (no SRAM activity; CE stays 1):
  - Write: hex register <= Data_CPU_In at the accept edge.
  - Read: Data_CPU_Out <= synchronized Switches at the accept edge.
  - Next state DONE, so Ack is in cycle 1 (accept = cycle 0).
- Accept with any other address: next state SETUP.
- SETUP (one cycle):
  - CE = UB = LB = 0; ADDR valid.
  - Read: OE = 0. Write: OE = 1, WE = 1.
  - Next state ACCESS; wait counter loads WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles):
  - CE, UB, LB and ADDR held.
  - Read: OE = 0; Data_CPU_Out <= Data_Mem_In on the edge ending the last ACCESS cycle.
  - Write: WE = 0 and Data_Mem_Out = latched data for all ACCESS cycles.
  - Counter decrements; leave to DONE when counter == 0.
- DONE:
  - Ack = 1 for exactly this cycle; all strobes inactive; next state IDLE.
- SRAM latency: Ack in cycle 2 + WAIT_CYCLES after accept (cycle 3 for the default).
- Data_CPU_Out holds its value until the next read completes; writes do not change it.
- Req dropping mid-access does not abort; the access completes and Ack is still issued.
- A, Wr and Data_CPU_In changes after accept are ignored.
- Switches pass through a 2-flop synchronizer; an IO read returns the synchronizer output at the accept edge.
- Hex outputs are register bits, not combinational from A or Data.
- Reset asserted mid-access: strobes deassert immediately, no Ack is produced, and Data_CPU_Out is cleared.
- OE and WE are never both 0 in the same cycle.

Test Plan:
- Reset mid-write: release reset; write 16'h1234 to 16'h0010 with W=1 → CE low in cycles 1–2, WE low only in cycle 2 with Data_Mem_Out=16'h1234, Ack in cycle 3, ADDR=20'h00010; assert Reset during ACCESS of a repeat write → all strobes high immediately, no Ack.
- SRAM read: model returns 16'hBEEF at 16'h0010; read → OE low in cycles 1–2, Ack in cycle 3, Data_CPU_Out=16'hBEEF from the Ack cycle onward and unchanged by a following write.
- IO write/read: write 16'hCAFE to 16'hFFFF → CE never low, Ack in cycle 1, HEX3..HEX0 = C,A,F,E. Set Switches=16'h00A5 and wait ≥2 cycles, then read 16'hFFFF → Data_CPU_Out=16'h00A5 at the cycle-1 Ack.
- Held request: keep Req high for 10 cycles after an Ack → exactly one access and one Ack. Drop Req one cycle, raise again → second access accepted.
- WAIT_CYCLES=4: read → ACCESS lasts 4 cycles, Ack in cycle 6. Toggle A and Wr during ACCESS → ADDR, OE and WE unchanged.
- Switch synchronization: change Switches from 16'h0000 to 16'hFFFF one cycle before an IO read accept → returns 16'h0000. With the change two or more cycles earlier → returns 16'hFFFF.
